stage4_mem: RTL and testbench

Pipeline stage 4 (memory access): sits directly downstream of the execute stage and consumes its registered ALU result, store operand, destination register and memory-op decode. Loads and stores go to data memory over a variable-latency req/ack handshake; non-memory results pass through. Produces the registered stage-4 result for writeback and a busy signal that freezes upstream stages while a memory access is outstanding.

---
 rtl/stage4_mem_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 85 ++++++++
 rtl/stage4_mem.sv | 160 ++++++++++++++++
 tb/tb_stage4_mem.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stage4_mem_pkg.sv
// Shared definitions for pipeline stage 4: word type, funct3 access encodings
// and the memory-access FSM states.
package stage4_mem_pkg;

  typedef logic [31:0] word;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store strobe/data placement and alignment
// fault detection on the incoming op, load extract/extend on the returned word.
module mem_lane_align
  import stage4_mem_pkg::*;
(
  input  logic       is_load_i,
  input  logic       is_store_i,
  input  logic [2:0] funct3_i,
  input  word        addr_i,
  input  word        store_value_i,
  input  logic [2:0] ld_funct3_i,
  input  logic [1:0] ld_offset_i,
  input  word        rdata_i,
  output logic [3:0] wstrb_o,
  output word        wdata_o,
  output logic       fault_o,
  output word        load_data_o
);

  logic       ld_fault;
  logic       st_fault;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = '0;
    case (funct3_i)
      F3_B: begin
        wstrb_o = 4'b0001 << addr_i[1:0];
        wdata_o = {4{store_value_i[7:0]}};
      end
      F3_H: begin
        wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_value_i[15:0]}};
      end
      F3_W: begin
        wstrb_o = 4'b1111;
        wdata_o = store_value_i;
      end
      default: ;
    endcase
  end

  // Unsigned variants only exist for loads; stores above SW are illegal.
  always_comb begin
    ld_fault = 1'b0;
    st_fault = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: ld_fault = 1'b0;
      F3_H, F3_HU: ld_fault = addr_i[0];
      F3_W:        ld_fault = |addr_i[1:0];
      default:     ld_fault = 1'b1;
    endcase
    case (funct3_i)
      F3_B:    st_fault = 1'b0;
      F3_H:    st_fault = addr_i[0];
      F3_W:    st_fault = |addr_i[1:0];
      default: st_fault = 1'b1;
    endcase
  end

  assign fault_o = (is_load_i & ld_fault) | (is_store_i & st_fault);

  always_comb begin
    case (ld_offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = ld_offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (ld_funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage4_mem.sv
// Pipeline stage 4: passes ALU results through, runs loads/stores over a
// variable-latency req/ack port and freezes upstream while an access is open.
module stage4_mem
  import stage4_mem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       stall,
  input  logic       valid,
  input  logic       is_load,
  input  logic       is_store,
  input  logic [2:0] funct3,
  input  logic [4:0] rd,
  input  word        eval,
  input  word        store_value,
  // mem_req rises the cycle after accept and holds, with addr/we/wstrb/wdata
  // stable, until the cycle mem_ack is high; mem_rdata is valid on that cycle.
  output logic       mem_req,
  output logic       mem_we,
  output word        mem_addr,
  output logic [3:0] mem_wstrb,
  output word        mem_wdata,
  input  logic       mem_ack,
  input  word        mem_rdata,
  output logic       mem_busy,
  output logic       s4_valid,
  output logic [4:0] s4_rd,
  output word        s4_result,
  output logic       s4_fault,
  output state_e     fsm_state
);

  state_e     state_q;
  logic       req_q, we_q;
  word        addr_q, wdata_q;
  logic [3:0] wstrb_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [4:0] rd_q;
  word        pend_result_q;
  logic [4:0] pend_rd_q;
  logic       s4_valid_q, s4_fault_q;
  logic [4:0] s4_rd_q;
  word        s4_result_q;

  logic       accept, is_mem, fault;
  logic [3:0] st_wstrb;
  word        st_wdata, load_data;
  word        wb_result_d;
  logic [4:0] wb_rd_d;

  mem_lane_align u_align (
    .is_load_i     (is_load),
    .is_store_i    (is_store),
    .funct3_i      (funct3),
    .addr_i        (eval),
    .store_value_i (store_value),
    .ld_funct3_i   (f3_q),
    .ld_offset_i   (off_q),
    .rdata_i       (mem_rdata),
    .wstrb_o       (st_wstrb),
    .wdata_o       (st_wdata),
    .fault_o       (fault),
    .load_data_o   (load_data)
  );

  assign accept      = (state_q == S_IDLE) & valid & ~stall;
  assign is_mem      = is_load | is_store;
  assign wb_result_d = we_q ? '0 : load_data;
  assign wb_rd_d     = we_q ? 5'd0 : rd_q;
  assign mem_busy    = (state_q != S_IDLE) | (accept & is_mem & ~fault);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= 4'b0000;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
      rd_q          <= 5'd0;
      pend_result_q <= '0;
      pend_rd_q     <= 5'd0;
      s4_valid_q    <= 1'b0;
      s4_fault_q    <= 1'b0;
      s4_rd_q       <= 5'd0;
      s4_result_q   <= '0;
    end else begin
      // Output is a one-cycle pulse; stall freezes it along with everything else.
      if (!stall) s4_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              s4_valid_q  <= 1'b1;
              s4_fault_q  <= 1'b0;
              s4_result_q <= eval;
              s4_rd_q     <= rd;
            end else if (fault) begin
              s4_valid_q  <= 1'b1;
              s4_fault_q  <= 1'b1;
              s4_result_q <= '0;
              s4_rd_q     <= 5'd0;
            end else begin
              req_q   <= 1'b1;
              we_q    <= is_store;
              addr_q  <= {eval[31:2], 2'b00};
              wstrb_q <= is_store ? st_wstrb : 4'b0000;
              wdata_q <= is_store ? st_wdata : '0;
              f3_q    <= funct3;
              off_q   <= eval[1:0];
              rd_q    <= rd;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (!stall) begin
              s4_valid_q  <= 1'b1;
              s4_fault_q  <= 1'b0;
              s4_result_q <= wb_result_d;
              s4_rd_q     <= wb_rd_d;
              state_q     <= S_IDLE;
            end else begin
              pend_result_q <= wb_result_d;
              pend_rd_q     <= wb_rd_d;
              state_q       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            s4_valid_q  <= 1'b1;
            s4_fault_q  <= 1'b0;
            s4_result_q <= pend_result_q;
            s4_rd_q     <= pend_rd_q;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign s4_valid  = s4_valid_q;
  assign s4_rd     = s4_rd_q;
  assign s4_result = s4_result_q;
  assign s4_fault  = s4_fault_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_stage4_mem.sv
// Bench for stage4_mem: directed cases plus randomized ops checked against a
// behavioural model, with a scoreboard popping expected stage-4 outputs.
module tb_stage4_mem;
  import stage4_mem_pkg::*;

  logic       clock, reset, stall, valid, is_load, is_store;
  logic [2:0] funct3;
  logic [4:0] rd;
  word        eval, store_value;
  logic       mem_req, mem_we, mem_ack, mem_busy;
  word        mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic       s4_valid, s4_fault;
  logic [4:0] s4_rd;
  word        s4_result;
  state_e     fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [37:0] exp_q[$];
  logic        edge_stall;

  stage4_mem dut (
    .clock(clock), .reset(reset), .stall(stall), .valid(valid),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .rd(rd),
    .eval(eval), .store_value(store_value), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .s4_valid(s4_valid), .s4_rd(s4_rd), .s4_result(s4_result),
    .s4_fault(s4_fault), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic logic model_fault(input logic ld, input logic st,
                                       input logic [2:0] f3, input word a);
    int size;
    if (!ld && !st) return 1'b0;
    if (ld) size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    else    size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
    if (size == 0) return 1'b1;
    return (a % size) != 0;
  endfunction

  function automatic word model_load(input logic [2:0] f3, input logic [1:0] off, input word rdata);
    word sh;
    sh = (f3 == 1 || f3 == 5) ? (rdata >> (16 * int'(off[1]))) : (rdata >> (8 * int'(off)));
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 0) return 4'b0001 << off;
    if (f3 == 1) return 4'b0011 << (2 * int'(off[1]));
    return 4'b1111;
  endfunction

  function automatic word model_wdata(input logic [2:0] f3, input word sv);
    if (f3 == 0) return {4{sv[7:0]}};
    if (f3 == 1) return {2{sv[15:0]}};
    return sv;
  endfunction

  // scoreboard: every written stage-4 output pops one expected {fault, rd, result}
  always @(posedge clock) edge_stall <= stall;

  always @(negedge clock) begin
    logic [37:0] e;
    if (!reset && s4_valid && !edge_stall) begin
      if (exp_q.size() == 0) begin
        check("s4_unexpected", {31'd0, s4_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("s4_fault", {31'd0, s4_fault}, {31'd0, e[37]});
        check("s4_rd", {27'd0, s4_rd}, {27'd0, e[36:32]});
        check("s4_result", s4_result, e[31:0]);
      end
    end
  end

  // driver: one op from accept through the stage-4 output cycle
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [4:0] rdv, input word ev, input word sv,
                        input word rdata, input int delay, input int stall_n);
    logic flt, legal;
    int   cnt;
    flt   = model_fault(ld, st, f3, ev);
    legal = (ld || st) && !flt;
    if (!ld && !st)  exp_q.push_back({1'b0, rdv, ev});
    else if (flt)    exp_q.push_back({1'b1, 5'd0, 32'd0});
    else if (ld)     exp_q.push_back({1'b0, rdv, model_load(f3, ev[1:0], rdata)});
    else             exp_q.push_back({1'b0, 5'd0, 32'd0});

    @(negedge clock);
    valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; rd = rdv;
    eval = ev; store_value = sv; stall = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check("busy_accept", {31'd0, mem_busy}, {31'd0, legal});
    cnt = mem_busy ? 1 : 0;
    @(negedge clock);
    valid = 1'b0; mem_ack = 1'b0;
    #1;
    if (!legal) begin
      check("no_req", {31'd0, mem_req}, 32'd0);
      check("s4_valid_t1", {31'd0, s4_valid}, 32'd1);
      return;
    end
    check("mem_we", {31'd0, mem_we}, {31'd0, st});
    check("mem_addr", mem_addr, {ev[31:2], 2'b00});
    if (st) begin
      check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, model_strb(f3, ev[1:0])});
      check("mem_wdata", mem_wdata, model_wdata(f3, sv));
    end
    for (int k = 0; k <= delay; k++) begin
      if (k > 0) begin @(negedge clock); #1; end
      cnt += mem_busy ? 1 : 0;
      check("req_held", {31'd0, mem_req}, 32'd1);
      check("s4_quiet_wait", {31'd0, s4_valid}, 32'd0);
      if (k == delay) begin
        mem_ack = 1'b1; mem_rdata = rdata; stall = (stall_n > 0);
      end
    end
    @(negedge clock);
    mem_ack = 1'b0; mem_rdata = $urandom;
    for (int h = 0; h < stall_n; h++) begin
      stall = (h < stall_n - 1);
      #1;
      cnt += mem_busy ? 1 : 0;
      check("hold_s4_valid", {31'd0, s4_valid}, 32'd0);
      check("hold_req", {31'd0, mem_req}, 32'd0);
      if (h == 0) check("hold_state", {30'd0, fsm_state}, {30'd0, S_HOLD});
      @(negedge clock);
    end
    #1;
    check("s4_valid_done", {31'd0, s4_valid}, 32'd1);
    check("busy_done", {31'd0, mem_busy}, 32'd0);
    check("busy_cycles", cnt, 2 + delay + stall_n);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; rd = 5'd0; eval = '0; store_value = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_s4_valid", {31'd0, s4_valid}, 32'd0);
    check("rst_s4_fault", {31'd0, s4_fault}, 32'd0);
    check("rst_s4_rd", {27'd0, s4_rd}, 32'd0);
    check("rst_s4_result", s4_result, 32'd0);
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // directed cases
    run_op(1'b0, 1'b0, 3'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 0, 0);
    check("alu_result", s4_result, 32'h1234_5678);
    check("alu_rd", {27'd0, s4_rd}, 32'd5);
    run_op(1'b1, 1'b0, F3_B, 5'd7, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 2, 0);
    check("lb_result", s4_result, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, F3_BU, 5'd7, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 2, 0);
    check("lbu_result", s4_result, 32'h0000_0080);
    run_op(1'b0, 1'b1, F3_H, 5'd9, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check("sh_rd", {27'd0, s4_rd}, 32'd0);
    run_op(1'b1, 1'b0, F3_W, 5'd3, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
    check("lw_fault", {31'd0, s4_fault}, 32'd1);
    check("lw_fault_result", s4_result, 32'd0);
    run_op(1'b1, 1'b0, F3_HU, 5'd4, 32'h0000_0002, 32'h0, 32'h8765_4321, 1, 2);
    check("lhu_hold_result", s4_result, 32'h0000_8765);

    // randomized ops
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // reset while waiting for ack
    @(negedge clock);
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = F3_W; rd = 5'd11; eval = 32'h40;
    @(negedge clock);
    valid = 1'b0;
    #1;
    check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_busy", {31'd0, mem_busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    check("rst_late_ack", {31'd0, s4_valid}, 32'd0);
    @(negedge clock);
    #1;
    check("rst_late_ack2", {31'd0, s4_valid}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
